// File: rtl/harvard_pkg.sv
// Shared definitions for the Harvard core front end.
// Holds the program word layout, the default HALT opcode and the fetch
// state encoding shared by the fetch unit and its bench.
package harvard_pkg;

   localparam int unsigned WORD_WIDTH    = 22;
   localparam int unsigned OPCODE_MSB    = 21;
   localparam int unsigned OPCODE_LSB    = 17;
   localparam int unsigned ADDRMODE_BIT  = 16;
   localparam int unsigned OPERAND_MSB   = 15;
   localparam int unsigned OPERAND_LSB   = 0;
   localparam int unsigned OPCODE_WIDTH  = OPCODE_MSB - OPCODE_LSB + 1;
   localparam int unsigned OPERAND_WIDTH = OPERAND_MSB - OPERAND_LSB + 1;

   localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 5'b11111;

   typedef enum logic [2:0] {
      FETCH_IDLE,
      FETCH_ISSUE,
      FETCH_CAPTURE,
      FETCH_DELIVER,
      FETCH_HALT
   } fetch_state_e;

   function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [WORD_WIDTH-1:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [OPERAND_WIDTH-1:0] operand_of(input logic [WORD_WIDTH-1:0] word);
      return word[OPERAND_MSB:OPERAND_LSB];
   endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// program_counter: fetch address register.
// Ports:
//   clk_i        clock, state on posedge
//   rst_ni       asynchronous active-low reset, loads RESET_VECTOR
//   load_i       load load_value_i (takes priority over increment)
//   load_value_i new PC value
//   inc_i        advance by one, wrapping modulo 2**ADDR_WIDTH
//   pc_o         current PC
// With neither load_i nor inc_i the PC holds.
module program_counter #(
   parameter int unsigned            ADDR_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_value_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_value_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks the program ROM (1-cycle synchronous read) and
// hands opcode / addressing mode / operand to the decoder.
// Ports:
//   ClockInput / ResetInput     clock, async active-low reset
//   ProgramAddressOutput        ROM address (always the PC)
//   ProgramDataInput            ROM word, valid the cycle after the address
//   OpecodeOutput, AddressingModeOutput, OperandOutput  captured fields
//   InstructionValidOutput      fields valid; accepted when StallInput=0
//   StallInput                  decoder not ready, hold instruction and PC
//   BranchTakenInput/BranchTargetInput  redirect fetch (low ADDR_WIDTH bits)
//   HaltedOutput                fetch stopped after delivering HALT_OPCODE
module instruction_fetch
   import harvard_pkg::*;
#(
   parameter int unsigned              ADDR_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0,
   parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE  = HALT_OPCODE_DEFAULT
) (
   input  logic                     ClockInput,
   input  logic                     ResetInput,
   output logic [ADDR_WIDTH-1:0]    ProgramAddressOutput,
   input  logic [WORD_WIDTH-1:0]    ProgramDataInput,
   output logic [OPCODE_WIDTH-1:0]  OpecodeOutput,
   output logic                     AddressingModeOutput,
   output logic [OPERAND_WIDTH-1:0] OperandOutput,
   output logic                     InstructionValidOutput,
   input  logic                     StallInput,
   input  logic                     BranchTakenInput,
   input  logic [15:0]              BranchTargetInput,
   output logic                     HaltedOutput
);

   fetch_state_e state_q, state_d;

   logic                     valid_q,  valid_d;
   logic                     halted_q, halted_d;
   logic [OPCODE_WIDTH-1:0]  opcode_q;
   logic                     mode_q;
   logic [OPERAND_WIDTH-1:0] operand_q;

   logic capture;
   logic pc_load;
   logic pc_inc;
   logic [ADDR_WIDTH-1:0] pc;

   generate
      if (ADDR_WIDTH < 16) begin : g_unused_target
         logic unused_target_bits;
         assign unused_target_bits = ^BranchTargetInput[15:ADDR_WIDTH];
      end
   endgenerate

   program_counter #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc (
      .clk_i       (ClockInput),
      .rst_ni      (ResetInput),
      .load_i      (pc_load),
      .load_value_i(BranchTargetInput[ADDR_WIDTH-1:0]),
      .inc_i       (pc_inc),
      .pc_o        (pc)
   );

   // A branch in ISSUE/CAPTURE/DELIVER always wins: the in-flight ROM word
   // is dropped by returning to ISSUE, and it overrides stall and HALT.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      capture  = 1'b0;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      unique case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_ISSUE;
         end
         FETCH_ISSUE: begin
            if (BranchTakenInput) begin
               pc_load = 1'b1;
               state_d = FETCH_ISSUE;
            end else begin
               state_d = FETCH_CAPTURE;
            end
         end
         FETCH_CAPTURE: begin
            if (BranchTakenInput) begin
               pc_load = 1'b1;
               valid_d = 1'b0;
               state_d = FETCH_ISSUE;
            end else begin
               capture = 1'b1;
               valid_d = 1'b1;
               pc_inc  = 1'b1;
               state_d = FETCH_DELIVER;
            end
         end
         FETCH_DELIVER: begin
            if (BranchTakenInput) begin
               pc_load = 1'b1;
               valid_d = 1'b0;
               state_d = FETCH_ISSUE;
            end else if (!StallInput) begin
               valid_d = 1'b0;
               if (opcode_q == HALT_OPCODE) begin
                  halted_d = 1'b1;
                  state_d  = FETCH_HALT;
               end else begin
                  state_d  = FETCH_ISSUE;
               end
            end
         end
         FETCH_HALT: begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            valid_d = 1'b0;
            state_d = FETCH_IDLE;
         end
      endcase
   end

   always_ff @(posedge ClockInput or negedge ResetInput) begin
      if (!ResetInput) begin
         state_q   <= FETCH_IDLE;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         opcode_q  <= '0;
         mode_q    <= 1'b0;
         operand_q <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         if (capture) begin
            opcode_q  <= opcode_of(ProgramDataInput);
            mode_q    <= ProgramDataInput[ADDRMODE_BIT];
            operand_q <= operand_of(ProgramDataInput);
         end
      end
   end

   assign ProgramAddressOutput   = pc;
   assign OpecodeOutput          = opcode_q;
   assign AddressingModeOutput   = mode_q;
   assign OperandOutput          = operand_q;
   assign InstructionValidOutput = valid_q;
   assign HaltedOutput           = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   localparam logic [4:0] HALT_OP = 5'b11111;

   typedef struct packed {
      logic [7:0]  addr;
      logic [21:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic [21:0] rom_data = '0;
   logic [4:0]  opcode;
   logic        amode;
   logic [15:0] operand;
   logic        valid;
   logic        stall;
   logic        branch;
   logic [15:0] target;
   logic        halted;

   logic [21:0] rom [256];
   exp_t        sb_q [$];
   logic [7:0]  model_pc;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   // Program ROM: synchronous, one cycle of read latency.
   always @(posedge clk) rom_data <= rom[addr];

   instruction_fetch #(
      .ADDR_WIDTH  (8),
      .RESET_VECTOR(8'h00),
      .HALT_OPCODE (HALT_OP)
   ) dut (
      .ClockInput            (clk),
      .ResetInput            (rst_n),
      .ProgramAddressOutput  (addr),
      .ProgramDataInput      (rom_data),
      .OpecodeOutput         (opcode),
      .AddressingModeOutput  (amode),
      .OperandOutput         (operand),
      .InstructionValidOutput(valid),
      .StallInput            (stall),
      .BranchTakenInput      (branch),
      .BranchTargetInput     (target),
      .HaltedOutput          (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [21:0] rand_word();
      logic [4:0] op;
      op = 5'($urandom_range(0, 30));
      return {op, 1'($urandom), 16'($urandom)};
   endfunction

   // Reference model: the program is walked sequentially; each issued
   // instruction's ROM word is expected at the decoder in order.
   task automatic push_next();
      exp_t e;
      e.addr = model_pc;
      e.word = rom[model_pc];
      sb_q.push_back(e);
      model_pc = model_pc + 8'd1;
   endtask

   // Monitor: inputs change just after posedge, so at negedge
   // valid && !stall means the decoder accepts on the coming edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid === 1'b1 && stall === 1'b0) begin
         if (sb_q.size() == 0) begin
            chk("sb_stray_accept", {opcode, amode, operand}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            logic [7:0] nxt;
            e = sb_q.pop_front();
            nxt = e.addr + 8'd1;
            chk("sb_word", {opcode, amode, operand}, e.word);
            chk("sb_pc_after_fetch", addr, nxt);
         end
      end
   end

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      chk("valid_timeout", valid, 1);
   endtask

   // Deliver one instruction: optional stall cycles (checking freeze),
   // then release with optional branch. kill keeps stall high on the
   // branch edge so the instruction is never accepted.
   task automatic step(input bit brk, input logic [15:0] tgt, input int unsigned nstall, input bit kill);
      bit ok;
      logic [21:0] held;
      logic [7:0]  held_pc;
      wait_valid(ok);
      if (!ok) return;
      held    = {opcode, amode, operand};
      held_pc = addr;
      if (nstall > 0) stall = 1'b1;
      for (int unsigned i = 0; i < nstall; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", valid, 1);
         chk("stall_fields", {opcode, amode, operand}, held);
         chk("stall_pc", addr, held_pc);
      end
      stall  = kill;
      branch = brk;
      target = tgt;
      @(posedge clk); #1;
      branch = 1'b0;
      stall  = 1'b0;
      chk("release_valid", valid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst_n  = 1'b0;
      stall  = 1'b0;
      branch = 1'b0;
      target = '0;
      for (int i = 0; i < 256; i++) rom[i] = rand_word();
      rom[0] = {5'd1, 1'b0, 16'h1111};  // ADD
      rom[1] = {5'd2, 1'b1, 16'h2222};  // SUB
      rom[2] = {5'd3, 1'b0, 16'h3333};  // LD
      rom[3] = {5'd4, 1'b1, 16'h4444};  // ST
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fields", {opcode, amode, operand}, 0);
      chk("rst_pc", addr, 0);

      // Straight-line: one instruction every 3 cycles
      model_pc = 8'h00;
      repeat (4) push_next();
      rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         chk("sl_valid", valid, (c % 3 == 0) ? 1 : 0);
         if (c % 3 == 0) chk("sl_pc", addr, c / 3);
      end

      // Stall on ST, then branch to 0x12FF (only low byte used) to test wrap
      step(1'b1, 16'h12FF, 4, 1'b0);
      model_pc = 8'hFF;
      push_next();
      push_next();
      step(1'b0, 16'h0000, 0, 1'b0);
      chk("wrap_pc", addr, 8'h00);
      // Accept word 0, branch to 5, then kill 5 with a branch in CAPTURE
      step(1'b1, 16'h0005, 0, 1'b0);
      chk("br_issue_pc", addr, 8'h05);
      @(posedge clk); #1;
      chk("br_capture_pc", addr, 8'h05);
      branch = 1'b1;
      target = 16'h0040;
      @(posedge clk); #1;
      branch = 1'b0;
      chk("br_redirect_pc", addr, 8'h40);
      chk("br_redirect_valid", valid, 0);
      model_pc = 8'h40;

      // Randomized walk with stalls, branches and killed instructions
      for (int k = 0; k < 30; k++) begin
         bit brk, kill;
         logic [15:0] tgt;
         int unsigned ns;
         brk  = ($urandom_range(0, 3) == 0);
         kill = brk && ($urandom_range(0, 2) == 0);
         tgt  = 16'($urandom);
         ns   = $urandom_range(0, 3);
         if (!kill) push_next();
         step(brk, tgt, ns, kill);
         if (brk) model_pc = tgt[7:0];
      end
      chk("rand_sb_empty", sb_q.size(), 0);

      // Halt: word 2 is HALT, delivered once then fetch stops for good
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      rom[0] = rand_word();
      rom[1] = rand_word();
      rom[2] = {HALT_OP, 1'b1, 16'hBEEF};
      model_pc = 8'h00;
      repeat (3) push_next();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         chk("halt_flag", halted, (c >= 10) ? 1 : 0);
         chk("halt_valid", valid, (c < 10 && c % 3 == 0) ? 1 : 0);
         if (c >= 10) chk("halt_pc", addr, 8'h03);
         if (c == 10) begin
            branch = 1'b1;
            target = 16'h0020;
            stall  = 1'b1;
         end
      end
      branch = 1'b0;
      stall  = 1'b0;
      chk("halt_sb_empty", sb_q.size(), 0);

      // Reset clears HALT; then reset again in the middle of a stalled DELIVER
      rst_n = 1'b0;
      #1;
      chk("halt_rst_clear", halted, 0);
      rom[2] = rand_word();
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_valid(ok);
      stall = 1'b1;
      @(posedge clk); #1;
      chk("mid_pre_valid", valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_halted", halted, 0);
      chk("mid_rst_fields", {opcode, amode, operand}, 0);
      chk("mid_rst_pc", addr, 0);
      @(posedge clk); #1;
      stall = 1'b0;
      model_pc = 8'h00;
      push_next();
      push_next();
      rst_n = 1'b1;
      step(1'b0, 16'h0000, 0, 1'b0);
      step(1'b0, 16'h0000, 1, 1'b0);
      chk("mid_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
